// File: rtl/apb_xbar_pkg.sv
// apb_xbar_pkg
//   Shared types and constants for the APB peripheral crossbar.
//   - rule_t       : inclusive {start_addr, end_addr} address window per port.
//                    The fields are 64 bits wide, so any ADDR_WIDTH up to 64
//                    can be decoded. Narrower addresses are zero-extended.
//   - xbar_state_e : crossbar FSM states.
//   - ERR_CNT_WIDTH: width of the saturating error counter.
package apb_xbar_pkg;

  localparam int unsigned ERR_CNT_WIDTH   = 16;
  localparam int unsigned RULE_ADDR_WIDTH = 64;

  typedef struct packed {
    logic [RULE_ADDR_WIDTH-1:0] start_addr;
    logic [RULE_ADDR_WIDTH-1:0] end_addr;
  } rule_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR,
    DONE
  } xbar_state_e;

endpackage

// File: rtl/apb_xbar_decode.sv
// apb_xbar_decode
//   Purely combinational address-rule matcher. A rule hits when
//   start_addr <= addr <= end_addr. When several rules hit, the lowest
//   index wins.
// Ports:
//   rules_i : NUM_SLAVES address windows
//   addr_i  : address to decode
//   sel_o   : one-hot select of the winning rule (all zero on a miss)
//   hit_o   : 1 when any rule matched
module apb_xbar_decode
  import apb_xbar_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 19,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  rule_t [NUM_SLAVES-1:0] rules_i,
  input  logic  [ADDR_WIDTH-1:0] addr_i,
  output logic  [NUM_SLAVES-1:0] sel_o,
  output logic                   hit_o
);

  logic [RULE_ADDR_WIDTH-1:0] addr_ext;

  assign addr_ext = RULE_ADDR_WIDTH'(addr_i);

  // Scan upwards and keep only the first match, so the lowest index wins.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o &&
          (addr_ext >= rules_i[i].start_addr) &&
          (addr_ext <= rules_i[i].end_addr)) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_periph_xbar.sv
// apb_periph_xbar
//   APB demultiplexer: one upstream completer port fanned out to NUM_SLAVES
//   peripheral ports through a runtime address-rule table. It has a
//   registered decode stage and answers unmapped addresses with a decode
//   error. An optional per-access watchdog can abort hung peripherals.
//
// Optional feature macro: APB_XBAR_TIMEOUT_EN
//   defined   -> ACCESS is aborted after TIMEOUT_CYCLES cycles without pready.
//   undefined -> ACCESS waits indefinitely. No counter is built.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   rules_i                per-port inclusive address windows (quasi-static)
//   s_p*_i / s_p*_o        upstream APB completer port
//   m_psel_o               one-hot peripheral select
//   m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o, m_pstrb_o, m_pprot_o
//                          broadcast to every peripheral from the request regs
//   m_pready_i, m_pslverr_i, m_prdata_i
//                          per-peripheral responses
//   err_count_o            saturating count of decode errors plus timeouts
module apb_periph_xbar
  import apb_xbar_pkg::*;
#(
  parameter int unsigned           NUM_SLAVES     = 19,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(32'hBADC_AB1E)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  rule_t [NUM_SLAVES-1:0]                 rules_i,
  input  logic                                   s_psel_i,
  input  logic                                   s_penable_i,
  input  logic                                   s_pwrite_i,
  input  logic [ADDR_WIDTH-1:0]                  s_paddr_i,
  input  logic [DATA_WIDTH-1:0]                  s_pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]                s_pstrb_i,
  input  logic [2:0]                             s_pprot_i,
  output logic                                   s_pready_o,
  output logic                                   s_pslverr_o,
  output logic [DATA_WIDTH-1:0]                  s_prdata_o,
  output logic [NUM_SLAVES-1:0]                  m_psel_o,
  output logic                                   m_penable_o,
  output logic                                   m_pwrite_o,
  output logic [ADDR_WIDTH-1:0]                  m_paddr_o,
  output logic [DATA_WIDTH-1:0]                  m_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]                m_pstrb_o,
  output logic [2:0]                             m_pprot_o,
  input  logic [NUM_SLAVES-1:0]                  m_pready_i,
  input  logic [NUM_SLAVES-1:0]                  m_pslverr_i,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  m_prdata_i,
  output logic [ERR_CNT_WIDTH-1:0]               err_count_o
);

  // Reject illegal configurations at elaboration time.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 64 || (DATA_WIDTH % 8) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_periph_xbar: illegal parameter combination");
  end

  xbar_state_e             state_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    abort_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic [DATA_WIDTH/8-1:0] req_strb_q;
  logic [2:0]              req_prot_q;
  logic                    req_write_q;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    pready_sel;
  logic                    pslverr_sel;
  logic                    abort_now;

`ifdef APB_XBAR_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  apb_xbar_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .rules_i (rules_i),
    .addr_i  (s_paddr_i),
    .sel_o   (dec_sel),
    .hit_o   (dec_hit)
  );

  // The broadcast signals come straight from the request registers.
  assign m_paddr_o  = req_addr_q;
  assign m_pwdata_o = req_wdata_q;
  assign m_pstrb_o  = req_strb_q;
  assign m_pprot_o  = req_prot_q;
  assign m_pwrite_o = req_write_q;

  // AND-OR mux of the selected peripheral's response. sel_q is one-hot,
  // so at most one term contributes.
  always_comb begin
    rdata_sel   = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        rdata_sel   = rdata_sel | m_prdata_i[i];
        pready_sel  = pready_sel | m_pready_i[i];
        pslverr_sel = pslverr_sel | m_pslverr_i[i];
      end
    end
  end

  // When upstream has dropped psel mid-transfer, the response is discarded.
  assign abort_now = abort_q | ~s_psel_i;

  // Main FSM. The request registers, the registered outputs and the error
  // counter all live here, so every output changes only on a clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      abort_q     <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      req_prot_q  <= '0;
      req_write_q <= 1'b0;
      m_psel_o    <= '0;
      m_penable_o <= 1'b0;
      s_pready_o  <= 1'b0;
      s_pslverr_o <= 1'b0;
      s_prdata_o  <= '0;
      err_count_o <= '0;
`ifdef APB_XBAR_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (s_psel_i && !s_penable_i) begin
            req_addr_q  <= s_paddr_i;
            req_wdata_q <= s_pwdata_i;
            req_strb_q  <= s_pstrb_i;
            req_prot_q  <= s_pprot_i;
            req_write_q <= s_pwrite_i;
            abort_q     <= 1'b0;
            sel_q       <= dec_sel;
            if (dec_hit) begin
              m_psel_o <= dec_sel;
              state_q  <= SETUP;
            end else begin
              state_q  <= ERR;
            end
          end
        end

        SETUP: begin
          if (!s_psel_i) abort_q <= 1'b1;
          m_penable_o <= 1'b1;
`ifdef APB_XBAR_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
          state_q     <= ACCESS;
        end

        ACCESS: begin
          if (!s_psel_i) abort_q <= 1'b1;
          // pready is checked first, so it wins over a timeout in the same cycle.
          if (pready_sel) begin
            m_psel_o    <= '0;
            m_penable_o <= 1'b0;
            s_pready_o  <= ~abort_now;
            s_pslverr_o <= ~abort_now & pslverr_sel;
            s_prdata_o  <= abort_now ? '0 : rdata_sel;
            state_q     <= DONE;
          end
`ifdef APB_XBAR_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            m_psel_o    <= '0;
            m_penable_o <= 1'b0;
            s_pready_o  <= ~abort_now;
            s_pslverr_o <= ~abort_now;
            s_prdata_o  <= abort_now ? '0 : ERR_RDATA;
            if (!abort_now && err_count_o != '1)
              err_count_o <= err_count_o + 1'b1;
            state_q     <= DONE;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        ERR: begin
          // Writes get zero read data. Reads get the error pattern.
          s_pready_o  <= ~abort_now;
          s_pslverr_o <= ~abort_now;
          s_prdata_o  <= (abort_now || req_write_q) ? '0 : ERR_RDATA;
          if (!abort_now && err_count_o != '1)
            err_count_o <= err_count_o + 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          s_pready_o  <= 1'b0;
          s_pslverr_o <= 1'b0;
          s_prdata_o  <= '0;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_xbar.sv
// tb_apb_periph_xbar
//   Directed scoreboard bench for apb_periph_xbar. Each upstream transfer
//   pushes its expected response. The response is popped and compared when
//   s_pready_o is seen. Latency is counted from the upstream SETUP cycle
//   (cycle 0).
module tb_apb_periph_xbar;
  import apb_xbar_pkg::*;

  localparam int NS = 19;
`ifdef APB_XBAR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    logic [NS-1:0] sel;
    int            lat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  rule_t [NS-1:0]       rules;
  logic                 psel, penable, pwrite;
  logic [31:0]          paddr, pwdata;
  logic [3:0]           pstrb;
  logic [2:0]           pprot;
  logic                 s_pready, s_pslverr;
  logic [31:0]          s_prdata;
  logic [NS-1:0]        m_psel;
  logic                 m_penable, m_pwrite;
  logic [31:0]          m_paddr, m_pwdata;
  logic [3:0]           m_pstrb;
  logic [2:0]           m_pprot;
  logic [NS-1:0]        m_pready, m_pslverr;
  logic [NS-1:0][31:0]  m_prdata;
  logic [15:0]          err_count;

  int   waits [NS];
  logic hang  [NS];
  int   acc_cnt;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  apb_periph_xbar #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hBADC_AB1E)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rules_i     (rules),
    .s_psel_i    (psel),
    .s_penable_i (penable),
    .s_pwrite_i  (pwrite),
    .s_paddr_i   (paddr),
    .s_pwdata_i  (pwdata),
    .s_pstrb_i   (pstrb),
    .s_pprot_i   (pprot),
    .s_pready_o  (s_pready),
    .s_pslverr_o (s_pslverr),
    .s_prdata_o  (s_prdata),
    .m_psel_o    (m_psel),
    .m_penable_o (m_penable),
    .m_pwrite_o  (m_pwrite),
    .m_paddr_o   (m_paddr),
    .m_pwdata_o  (m_pwdata),
    .m_pstrb_o   (m_pstrb),
    .m_pprot_o   (m_pprot),
    .m_pready_i  (m_pready),
    .m_pslverr_i (m_pslverr),
    .m_prdata_i  (m_prdata),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  // Peripheral model: counts ACCESS cycles and raises pready once the
  // configured number of wait states has elapsed.
  always @(posedge clk) begin
    if (!rst_ni || !m_penable || (|m_pready)) acc_cnt <= 0;
    else                                      acc_cnt <= acc_cnt + 1;
  end

  always_comb begin
    m_pready = '0;
    for (int i = 0; i < NS; i++)
      m_pready[i] = m_psel[i] & m_penable & ~hang[i] & (acc_cnt >= waits[i]);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one upstream APB transfer and checks it against the scoreboard.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic [NS-1:0] exp_sel, input int exp_lat);
    exp_t          e, got;
    int            cyc;
    logic [NS-1:0] seen_sel;
    logic          bc_checked;
    e.rdata = exp_rdata; e.err = exp_err; e.sel = exp_sel; e.lat = exp_lat;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    pstrb = 4'hF; pprot = 3'b010;
    sb.push_back(e);
    cyc = 0; seen_sel = '0; bc_checked = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_resp"}, {s_pready, s_pslverr, s_prdata}, '0);
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) penable = 1'b1;
      @(negedge clk);
      seen_sel |= m_psel;
      if (|m_psel && !bc_checked) begin
        bc_checked = 1'b1;
        checkOutput({tag, "_paddr"}, m_paddr, addr);
        checkOutput({tag, "_pwrite_pwdata_pstrb"}, {m_pwrite, m_pwdata, m_pstrb}, {wr, wdata, 4'hF});
      end
      if (s_pready) break;
      if (cyc > 200) begin
        checks++; errors++;
        $display("[TB] FAIL %s_bound: no pready after %0d cycles, required by cycle %0d", tag, cyc, exp_lat);
        break;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s_sb: response with empty scoreboard", tag);
    end else begin
      got = sb.pop_front();
      checkOutput({tag, "_latency"}, cyc, got.lat);
      checkOutput({tag, "_prdata"}, s_prdata, got.rdata);
      checkOutput({tag, "_pslverr"}, s_pslverr, got.err);
      checkOutput({tag, "_psel"}, seen_sel, got.sel);
    end
  endtask

  task automatic releaseBus(input int n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Upstream drops psel after drop_cyc cycles. The peripheral access must
  // still happen, but no response and no error count may appear.
  task automatic violate(input string tag, input logic [31:0] addr, input int drop_cyc,
                         input logic [NS-1:0] exp_sel);
    logic [NS-1:0] seen_sel;
    logic          any_ready;
    logic [15:0]   cnt0;
    cnt0 = err_count;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    seen_sel = '0; any_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) penable = 1'b1;
      if (c == drop_cyc) begin psel = 1'b0; penable = 1'b0; end
      @(negedge clk);
      seen_sel |= m_psel;
      any_ready |= s_pready;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_no_pready"}, any_ready, 1'b0);
    checkOutput({tag, "_psel_seen"}, seen_sel, exp_sel);
    checkOutput({tag, "_psel_released"}, m_psel, '0);
    checkOutput({tag, "_err_count"}, err_count, cnt0);
  endtask

  initial begin
    rst_ni = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    for (int i = 0; i < NS; i++) begin
      rules[i].start_addr = 64'h2000_0000 + 64'(i) * 64'h1000;
      rules[i].end_addr   = 64'h2000_0FFF + 64'(i) * 64'h1000;
      m_prdata[i]  = 32'hA000_0000 | 32'(i);
      m_pslverr[i] = 1'b0;
      waits[i]     = 0;
      hang[i]      = 1'b0;
    end
    rules[4] = '{start_addr: 64'h1A10_1000, end_addr: 64'h1A10_1FFF};
    rules[2] = '{start_addr: 64'h1A10_2000, end_addr: 64'h1A10_2FFF};
    rules[5] = '{start_addr: 64'h1A10_2000, end_addr: 64'h1A10_3FFF};
    m_prdata[4]  = 32'h1234_5678;
    m_pslverr[1] = 1'b1;
    waits[7]     = 3;
    hang[3]      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_up", {s_pready, s_pslverr, s_prdata}, '0);
    checkOutput("reset_psel_pen", {m_psel, m_penable, m_pwrite}, '0);
    checkOutput("reset_bcast", {m_paddr, m_pwdata}, '0);
    checkOutput("reset_strb_prot_cnt", {m_pstrb, m_pprot, err_count}, '0);
    @(posedge clk); #1; rst_ni = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] mapped read");
    applyStimulus("mapped_rd", 32'h1A10_1008, 1'b0, 32'h0, 32'h1234_5678, 1'b0, NS'(1) << 4, 3);
    releaseBus(1);

    $display("[TB] overlap priority write");
    applyStimulus("overlap_wr", 32'h1A10_2000, 1'b1, 32'hCAFE_F00D, 32'hA000_0002, 1'b0, NS'(1) << 2, 3);
    releaseBus(1);

    $display("[TB] unmapped accesses");
    applyStimulus("unmapped_rd", 32'h0000_0000, 1'b0, 32'h0, 32'hBADC_AB1E, 1'b1, '0, 2);
    checkOutput("unmapped_rd_cnt", err_count, 16'd1);
    releaseBus(1);
    applyStimulus("unmapped_wr", 32'hFFFF_FFF0, 1'b1, 32'h5555_AAAA, 32'h0, 1'b1, '0, 2);
    checkOutput("unmapped_wr_cnt", err_count, 16'd2);
    releaseBus(1);

    $display("[TB] peripheral slave error");
    applyStimulus("slverr_rd", 32'h2000_1010, 1'b0, 32'h0, 32'hA000_0001, 1'b1, NS'(1) << 1, 3);
    checkOutput("slverr_cnt", err_count, 16'd2);
    releaseBus(1);

    $display("[TB] wait states then back-to-back");
    applyStimulus("wait7", 32'h2000_7004, 1'b0, 32'h0, 32'hA000_0007, 1'b0, NS'(1) << 7, 6);
    applyStimulus("b2b0", 32'h2000_0000, 1'b1, 32'h1357_9BDF, 32'hA000_0000, 1'b0, NS'(1), 3);
    releaseBus(1);
    checkOutput("b2b_sb_empty", sb.size(), 0);

    $display("[TB] upstream protocol violations");
    violate("viol_unmapped", 32'h0000_0100, 1, '0);
    violate("viol_mapped", 32'h2000_7000, 2, NS'(1) << 7);

`ifdef APB_XBAR_TIMEOUT_EN
    $display("[TB] timeout");
    hang[0] = 1'b1;
    applyStimulus("timeout", 32'h2000_0000, 1'b0, 32'h0, 32'hBADC_AB1E, 1'b1, NS'(1), 10);
    checkOutput("timeout_cnt", err_count, 16'd3);
    releaseBus(1);
    hang[0] = 1'b0; waits[0] = 7;
    applyStimulus("late_ready", 32'h2000_0000, 1'b0, 32'h0, 32'hA000_0000, 1'b0, NS'(1), 10);
    checkOutput("late_ready_cnt", err_count, 16'd3);
    releaseBus(1);
    waits[0] = 0;
`endif

    $display("[TB] reset mid-ACCESS");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h2000_3000;
    for (int c = 0; c < 20 && !m_penable; c++) begin
      @(posedge clk); #1; penable = 1'b1;
    end
    @(negedge clk);
    checkOutput("midrst_in_access", {m_penable, m_psel}, {1'b1, NS'(1) << 3});
    rst_ni = 1'b0;
    @(negedge clk);
    checkOutput("midrst_psel_pen", {m_psel, m_penable}, '0);
    checkOutput("midrst_up", {s_pready, s_pslverr, s_prdata}, '0);
    checkOutput("midrst_paddr_cnt", {m_paddr, err_count}, '0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus("post_rst", 32'h1A10_1ABC, 1'b0, 32'h0, 32'h1234_5678, 1'b0, NS'(1) << 4, 3);
    releaseBus(2);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
